// File: rtl/sdm_dac_2nd_order.sv
// rtl/sdm_dac_2nd_order.sv - stereo second-order delta-sigma PDM modulator
// Zero-order-hold input latch, divided modulator tick, IDLE/RUN mute FSM.
module sdm_dac_2nd_order #(
  parameter int TICK_DIV      = 8,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_in_rdy,
  input  logic signed [17:0] sample_in_l,
  input  logic signed [17:0] sample_in_r,
  output logic               dac_out_l,
  output logic               dac_out_r,
  output logic               tick,
  output logic               clip,
  output logic               active
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int TW = 10;
  localparam logic signed [17:0] X_MAX = 18'sd98304;
  localparam logic signed [17:0] X_MIN = -18'sd98304;
  localparam logic signed [25:0] FB    = 26'sd131072;
  localparam logic signed [25:0] I_MAX = 26'sd8388607;
  localparam logic signed [25:0] I_MIN = -26'sd8388608;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      to_q, to_d;
  logic signed [17:0] x_in [2];
  logic signed [17:0] x_cl [2];
  logic signed [17:0] x_hold_q [2];
  logic signed [17:0] x_hold_d [2];
  logic signed [23:0] i1_q [2];
  logic signed [23:0] i1_d [2];
  logic signed [23:0] i2_q [2];
  logic signed [23:0] i2_d [2];
  logic signed [23:0] i1_n [2];
  logic signed [23:0] i2_n [2];
  logic [1:0]         dac_q, dac_d;
  logic               clip_q, clip_d;
  logic               clamped;
  logic               terminal;

  function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
    if (v > I_MAX) return 24'sh7FFFFF;
    else if (v < I_MIN) return 24'sh800000;
    else return v[23:0];
  endfunction

  assign x_in[0] = sample_in_l;
  assign x_in[1] = sample_in_r;

  assign tick     = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d    = tick ? '0 : cnt_q + CW'(1);
  // A strobe on the terminal tick keeps the modulator in RUN.
  assign terminal = tick && !sample_in_rdy && (to_q == TW'(TIMEOUT_TICKS - 1));

  always_comb begin
    clamped = 1'b0;
    for (int c = 0; c < 2; c++) begin
      x_cl[c] = x_in[c];
      if (x_in[c] > X_MAX) begin
        x_cl[c] = X_MAX;
        clamped = 1'b1;
      end else if (x_in[c] < X_MIN) begin
        x_cl[c] = X_MIN;
        clamped = 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      i1_n[c] = sat24(26'(i1_q[c]) + 26'(x_hold_q[c]) - (dac_q[c] ? FB : -FB));
      i2_n[c] = sat24(26'(i2_q[c]) + 26'(i1_q[c]) - (dac_q[c] ? FB : -FB));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_in_rdy) state_d = RUN;
      RUN:     if (terminal) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == RUN);
  end

  always_comb begin
    to_d   = to_q;
    dac_d  = dac_q;
    clip_d = 1'b0;
    for (int c = 0; c < 2; c++) begin
      x_hold_d[c] = x_hold_q[c];
      i1_d[c]     = i1_q[c];
      i2_d[c]     = i2_q[c];
    end
    if (sample_in_rdy) begin
      clip_d = clamped;
      for (int c = 0; c < 2; c++) x_hold_d[c] = x_cl[c];
    end
    if (state_q == IDLE) begin
      to_d = '0;
      for (int c = 0; c < 2; c++) begin
        i1_d[c] = '0;
        i2_d[c] = '0;
      end
      if (tick && !sample_in_rdy) dac_d = ~dac_q;
    end else begin
      if (tick) begin
        for (int c = 0; c < 2; c++) begin
          i1_d[c]  = i1_n[c];
          i2_d[c]  = i2_n[c];
          dac_d[c] = ~i2_n[c][23];
        end
      end
      if (sample_in_rdy) begin
        to_d = '0;
      end else if (terminal) begin
        to_d = '0;
        for (int c = 0; c < 2; c++) begin
          i1_d[c]     = '0;
          i2_d[c]     = '0;
          x_hold_d[c] = '0;
        end
      end else if (tick) begin
        to_d = to_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      to_q   <= '0;
      dac_q  <= '0;
      clip_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        x_hold_q[c] <= '0;
        i1_q[c]     <= '0;
        i2_q[c]     <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      to_q   <= to_d;
      dac_q  <= dac_d;
      clip_q <= clip_d;
      for (int c = 0; c < 2; c++) begin
        x_hold_q[c] <= x_hold_d[c];
        i1_q[c]     <= i1_d[c];
        i2_q[c]     <= i2_d[c];
      end
    end
  end

  assign dac_out_l = dac_q[0];
  assign dac_out_r = dac_q[1];
  assign clip      = clip_q;
endmodule

// File: tb/tb_sdm_dac_2nd_order.sv
// tb/tb_sdm_dac_2nd_order.sv - randomized self-checking bench for sdm_dac_2nd_order
// Tick-level reference model with integer arithmetic; tasks per scenario.
module tb_sdm_dac_2nd_order;
  localparam int TD = 8;
  localparam int TO = 64;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               rdy = 1'b0;
  logic signed [17:0] in_l = '0;
  logic signed [17:0] in_r = '0;
  logic               dac_out_l, dac_out_r, tick, clip, active;

  int total = 0;
  int bad   = 0;
  int iv_err;

  bit       m_run;
  int       m_i1 [2];
  int       m_i2 [2];
  int       m_x  [2];
  bit [1:0] m_dac;
  int       m_to;

  sdm_dac_2nd_order #(.TICK_DIV(TD), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(reset), .sample_in_rdy(rdy),
    .sample_in_l(in_l), .sample_in_r(in_r),
    .dac_out_l(dac_out_l), .dac_out_r(dac_out_r),
    .tick(tick), .clip(clip), .active(active)
  );

  always #5 clk = ~clk;

  function automatic int clamp_x(input int v);
    if (v > 98304) return 98304;
    if (v < -98304) return -98304;
    return v;
  endfunction

  function automatic int sat_i(input int v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_dac = 2'b00; m_to = 0;
    for (int c = 0; c < 2; c++) begin m_i1[c] = 0; m_i2[c] = 0; m_x[c] = 0; end
  endtask

  task automatic model_latch(input int l, input int r, output bit ec);
    m_x[0] = clamp_x(l);
    m_x[1] = clamp_x(r);
    ec = (m_x[0] != l) || (m_x[1] != r);
  endtask

  task automatic model_strobe(input int l, input int r, output bit ec);
    model_latch(l, r, ec);
    if (!m_run) begin
      m_run = 1;
      for (int c = 0; c < 2; c++) begin m_i1[c] = 0; m_i2[c] = 0; end
    end
    m_to = 0;
  endtask

  task automatic model_tick(input bit s, input int l, input int r, output bit ec);
    int fb, n1, n2;
    ec = 0;
    if (!m_run) begin
      if (s) begin
        m_run = 1; m_to = 0;
        for (int c = 0; c < 2; c++) begin m_i1[c] = 0; m_i2[c] = 0; end
      end else begin
        m_dac = ~m_dac;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        fb = m_dac[c] ? 131072 : -131072;
        n1 = sat_i(m_i1[c] + m_x[c] - fb);
        n2 = sat_i(m_i2[c] + m_i1[c] - fb);
        m_i1[c] = n1; m_i2[c] = n2;
        m_dac[c] = (n2 >= 0);
      end
      if (s) m_to = 0;
      else if (m_to + 1 >= TO) begin
        m_run = 0; m_to = 0;
        for (int c = 0; c < 2; c++) begin m_i1[c] = 0; m_i2[c] = 0; m_x[c] = 0; end
      end else m_to++;
    end
    if (s) model_latch(l, r, ec);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic strobe_part(input int l, input int r);
    bit ec;
    rdy = 1; in_l = 18'(l); in_r = 18'(r);
    model_strobe(l, r, ec);
    cyc(); rdy = 0;
    if (clip !== ec || active !== m_run) iv_err++;
  endtask

  task automatic tick_part(input bit s, input int l, input int r, input int exp_wait);
    int n;
    bit ec;
    n = 0;
    while (tick !== 1'b1 && n < 2 * TD) begin cyc(); n++; end
    if (tick !== 1'b1) begin iv_err++; return; end
    if (n != exp_wait) iv_err++;
    if (dac_out_l !== m_dac[0] || dac_out_r !== m_dac[1]) iv_err++;
    if (s) begin rdy = 1; in_l = 18'(l); in_r = 18'(r); end
    model_tick(s, l, r, ec);
    cyc(); rdy = 0;
    if (dac_out_l !== m_dac[0] || dac_out_r !== m_dac[1] || active !== m_run || clip !== ec) iv_err++;
  endtask

  task automatic interval(input bit s, input bit coinc, input int l, input int r);
    if (s && !coinc) begin
      strobe_part(l, r);
      tick_part(1'b0, 0, 0, TD - 2);
    end else begin
      tick_part(s, l, r, TD - 1);
    end
  endtask

  task automatic report_iv(input string name);
    total++;
    if (iv_err !== 0) begin bad++; $display("FAIL %s model_errors=%0d required=0", name, iv_err); end
  endtask

  task automatic check_idle_pattern(input string name);
    logic [5:0] pl, pr;
    iv_err = 0; pl = '0; pr = '0;
    for (int k = 0; k < 6; k++) begin
      interval(1'b0, 1'b0, 0, 0);
      pl = {pl[4:0], dac_out_l};
      pr = {pr[4:0], dac_out_r};
    end
    total++;
    if (pl !== 6'b101010 || pr !== 6'b101010) begin
      bad++; $display("FAIL %s_pattern got l=%b r=%b required 101010", name, pl, pr);
    end
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL %s_active got=%b required=0", name, active); end
    report_iv(name);
  endtask

  task automatic test_reset();
    #2 reset = 0;
    repeat (3) cyc();
    total++;
    if ({dac_out_l, dac_out_r, tick, clip, active} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b required=00000", {dac_out_l, dac_out_r, tick, clip, active});
    end
    total++;
    if (dut.x_hold_q[0] !== 18'sd0 || dut.i1_q[0] !== 24'sd0 || dut.i2_q[1] !== 24'sd0) begin
      bad++; $display("FAIL reset_state x=%0d i1=%0d i2=%0d required 0", dut.x_hold_q[0], dut.i1_q[0], dut.i2_q[1]);
    end
    @(posedge clk); #1 reset = 1;
    model_reset();
  endtask

  task automatic test_idle();
    check_idle_pattern("idle");
  endtask

  task automatic test_zero_run();
    logic [3:0] pl, pr;
    iv_err = 0; pl = '0; pr = '0;
    interval(1'b1, 1'b0, 0, 0);
    pl = {pl[2:0], dac_out_l}; pr = {pr[2:0], dac_out_r};
    for (int k = 0; k < 3; k++) begin
      interval(1'b0, 1'b0, 0, 0);
      pl = {pl[2:0], dac_out_l}; pr = {pr[2:0], dac_out_r};
    end
    total++;
    if (pl !== 4'b1110 || pr !== 4'b1110) begin
      bad++; $display("FAIL zero_run_bits got l=%b r=%b required 1110", pl, pr);
    end
    total++;
    if (dut.i1_q[0] !== -24'sd262144 || dut.i2_q[0] !== -24'sd262144) begin
      bad++; $display("FAIL zero_run_integrators i1=%0d i2=%0d required -262144", dut.i1_q[0], dut.i2_q[0]);
    end
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL zero_run_active got=%b required=1", active); end
    report_iv("zero_run");
  endtask

  task automatic test_timeout();
    int fall;
    iv_err = 0; fall = 0;
    interval(1'b1, 1'b0, 0, 0);
    for (int i = 2; i <= 72; i++) begin
      interval(1'b0, 1'b0, 0, 0);
      if (active !== 1'b1 && fall == 0) fall = i;
    end
    total++;
    if (fall != TO) begin bad++; $display("FAIL timeout_fall_tick got=%0d required=%0d", fall, TO); end
    report_iv("timeout_idle");
    iv_err = 0;
    interval(1'b1, 1'b0, 0, 0);
    for (int i = 2; i < TO; i++) interval(1'b0, 1'b0, 0, 0);
    interval(1'b1, 1'b1, 0, 0);
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL timeout_coincident got active=%b required=1", active); end
    for (int i = 0; i < 10; i++) interval(1'b0, 1'b0, 0, 0);
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL timeout_restart got active=%b required=1", active); end
    report_iv("timeout_coincident");
  endtask

  task automatic test_clip();
    iv_err = 0;
    strobe_part(131071, -131072);
    total++;
    if (clip !== 1'b1) begin bad++; $display("FAIL clip_pulse got=%b required=1", clip); end
    cyc();
    total++;
    if (clip !== 1'b0) begin bad++; $display("FAIL clip_single got=%b required=0", clip); end
    total++;
    if (dut.x_hold_q[0] !== 18'sd98304 || dut.x_hold_q[1] !== -18'sd98304) begin
      bad++; $display("FAIL clip_hold got l=%0d r=%0d required 98304/-98304", dut.x_hold_q[0], dut.x_hold_q[1]);
    end
    tick_part(1'b0, 0, 0, TD - 3);
    interval(1'b1, 1'b0, 98304, -98304);
    interval(1'b1, 1'b0, 98305, 0);
    interval(1'b1, 1'b1, 0, -98305);
    interval(1'b1, 1'b0, 1000, -1000);
    report_iv("clip");
  endtask

  task automatic test_dc();
    int ol, orr, ml, mr;
    iv_err = 0; ol = 0; orr = 0; ml = 0; mr = 0;
    for (int k = 0; k < 1024; k++) begin
      interval(1'b1, 1'b0, 65536, -65536);
      ol += int'(dac_out_l); orr += int'(dac_out_r);
      ml += int'(m_dac[0]);  mr += int'(m_dac[1]);
    end
    total++;
    if (ol != ml || orr != mr) begin
      bad++; $display("FAIL dc_counts got l=%0d r=%0d required l=%0d r=%0d", ol, orr, ml, mr);
    end
    total++;
    if (ol < 766 || ol > 770 || orr < 254 || orr > 258) begin
      bad++; $display("FAIL dc_density got l=%0d r=%0d required 768+-2 / 256+-2", ol, orr);
    end
    report_iv("dc");
  endtask

  task automatic test_random();
    int l, r;
    bit s, co;
    iv_err = 0;
    for (int k = 0; k < 300; k++) begin
      s  = ($urandom_range(1, 0) == 1);
      co = ($urandom_range(3, 0) == 0);
      l  = int'($urandom_range(262143, 0)) - 131072;
      r  = int'($urandom_range(262143, 0)) - 131072;
      interval(s, co, l, r);
    end
    report_iv("random");
  endtask

  task automatic test_reset_mid();
    iv_err = 0;
    interval(1'b1, 1'b0, 50000, -20000);
    interval(1'b0, 1'b0, 0, 0);
    @(posedge clk); #3 reset = 0; #1;
    total++;
    if ({dac_out_l, dac_out_r, tick, clip, active} !== 5'b0) begin
      bad++; $display("FAIL reset_mid_outputs got=%b required=00000", {dac_out_l, dac_out_r, tick, clip, active});
    end
    total++;
    if (dut.x_hold_q[0] !== 18'sd0 || dut.i1_q[0] !== 24'sd0) begin
      bad++; $display("FAIL reset_mid_state x=%0d i1=%0d required 0", dut.x_hold_q[0], dut.i1_q[0]);
    end
    report_iv("reset_mid_pre");
    repeat (2) cyc();
    @(posedge clk); #1 reset = 1;
    model_reset();
    check_idle_pattern("reset_mid_idle");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_zero_run();
    test_timeout();
    test_clip();
    test_dc();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
